// File: rtl/seq_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   - state_t        : FSM state encoding (idle, shifting, inter-repetition gap, done)
//   - DEF_PAT_W/DEF_REP_W/DEF_GAP : default parameter values
//   - idx_w()        : width of an index/counter able to hold 0..n-1 (minimum 1 bit)
package seq_pattern_gen_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_REP_W = 4;
  localparam int DEF_GAP   = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Request/stream bundle of the serial pattern generator.
//   master (requester): drives start, pattern, len, reps, idle_bit;
//                       receives dout, dout_valid, busy, frame_end, done
//   slave  (generator): the reverse
interface seq_pattern_gen_if
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int REP_W = DEF_REP_W
) ();

  localparam int LEN_W = idx_w(PAT_W);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] len;
  logic [REP_W-1:0] reps;
  logic             idle_bit;
  logic             dout;
  logic             dout_valid;
  logic             busy;
  logic             frame_end;
  logic             done;

  modport master (
    output start, pattern, len, reps, idle_bit,
    input  dout, dout_valid, busy, frame_end, done
  );

  modport slave (
    input  start, pattern, len, reps, idle_bit,
    output dout, dout_valid, busy, frame_end, done
  );

endinterface

// File: rtl/seq_pattern_gen_pat_shreg.sv
// Loadable pattern register with a down-counting bit index.
//   clk, rst  : clock, asynchronous active-low reset (index only)
//   load      : capture pattern/len and point the index at bit len
//   restart   : point the index back at the captured len (new repetition)
//   advance   : step the index down by one
//   pattern   : word to capture
//   len       : index of the first (MSB) bit to send
//   bit_out   : currently selected pattern bit
//   last      : index has reached bit 0
module pat_shreg
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = idx_w(DEF_PAT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             restart,
  input  logic             advance,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  output logic             bit_out,
  output logic             last
);

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx;

  // Captured word and length are pure data: no reset needed, they are only
  // observed while shifting, which always follows a load.
  always_ff @(posedge clk) begin
    if (load) begin
      pat_q <= pattern;
      len_q <= len;
    end
  end

  // The top only requests advance when the index is non-zero, so it never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= len;
    end else if (restart) begin
      idx <= len_q;
    end else if (advance) begin
      idx <= idx - LEN_W'(1);
    end
  end

  assign bit_out = pat_q[idx];
  assign last    = (idx == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern generator: sends pattern[len..0] MSB-first, reps+1 times,
// separated by GAP idle cycles, then pulses done for one cycle.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of seq_pattern_gen_if (request in, bitstream/status out)
// Parameters: PAT_W (max pattern bits), REP_W (repetition count width),
//             GAP (idle cycles between repetitions, 0 allowed).
module seq_pattern_gen
  import seq_pattern_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int REP_W = DEF_REP_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic                clk,
  input  logic                rst,
  seq_pattern_gen_if.slave    bus
);

  localparam int                LEN_W    = idx_w(PAT_W);
  localparam int                GAP_CW   = idx_w(GAP);
  localparam logic [GAP_CW-1:0] GAP_LOAD = GAP_CW'((GAP > 0) ? GAP - 1 : 0);

  state_t            state;
  logic [REP_W-1:0]  rep_cnt;
  logic [GAP_CW-1:0] gap_cnt;
  logic              idle_q;

  logic accept;
  logic more_reps;
  logic restart;
  logic advance;
  logic cur_bit;
  logic last_bit;

  // A new request is only honoured when not busy; while busy every input is ignored.
  assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && bus.start;
  assign more_reps = (rep_cnt != '0);
  // Index reloads either straight after bit 0 (no gap) or at the end of the gap.
  assign restart   = ((state == ST_SHIFT) && last_bit && more_reps && (GAP == 0))
                   || ((state == ST_GAP) && (gap_cnt == '0));
  assign advance   = (state == ST_SHIFT) && !last_bit;

  pat_shreg #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .restart (restart),
    .advance (advance),
    .pattern (bus.pattern),
    .len     (bus.len),
    .bit_out (cur_bit),
    .last    (last_bit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      rep_cnt <= '0;
      gap_cnt <= '0;
      idle_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (accept) begin
            state   <= ST_SHIFT;
            rep_cnt <= bus.reps;
            idle_q  <= bus.idle_bit;
          end else begin
            state   <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          if (last_bit) begin
            if (more_reps) begin
              // Counter stops at zero, so reps at full scale gives 2^REP_W frames.
              rep_cnt <= rep_cnt - REP_W'(1);
              if (GAP > 0) begin
                state   <= ST_GAP;
                gap_cnt <= GAP_LOAD;
              end
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            state <= ST_SHIFT;
          end else begin
            gap_cnt <= gap_cnt - GAP_CW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Moore decode from registered state and pattern datapath.
  assign bus.dout       = (state == ST_SHIFT) ? cur_bit : idle_q;
  assign bus.dout_valid = (state == ST_SHIFT);
  assign bus.busy       = (state == ST_SHIFT) || (state == ST_GAP);
  assign bus.frame_end  = (state == ST_SHIFT) && last_bit;
  assign bus.done       = (state == ST_DONE);

endmodule
